// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-stage load/store unit: access sizes, write masks, FSM states.
// Pure declarations; no latency or flow control of its own.
package mem_access_pkg;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    localparam logic [3:0] WM_BYTE = 4'b0001;
    localparam logic [3:0] WM_HALF = 4'b0011;
    localparam logic [3:0] WM_WORD = 4'b1111;

    localparam int TIMEOUT_DEFAULT = 16;
    localparam int CNT_W_DEFAULT   = $clog2(TIMEOUT_DEFAULT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load lane select plus sign/zero extension from a little-endian bus word.
// Purely combinational, zero latency; no flow control.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_size)
            SZ_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: aligns/replicates stores, extends loads, watchdogs a word-wide bus.
// Latency 2 cycles plus bus wait states (1 for rejected requests); stalls upstream while in flight.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_op_valid,
    input  logic [3:0]  i_mem_write,
    input  logic [1:0]  i_mem_read,
    input  logic        i_mem_to_reg,
    input  logic        i_load_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_load_data,
    output logic        o_align_err,
    output logic        o_bus_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [3:0]  o_bus_be,
    output logic [29:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_ack
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic             r_align_err;
    logic             r_bus_err;
    logic             r_bus_req;
    logic             r_bus_we;
    logic [3:0]       r_bus_be;
    logic [29:0]      r_bus_addr;
    logic [31:0]      r_bus_wdata;
    logic [31:0]      r_load_data;

    logic             w_req;
    logic [1:0]       w_size;
    logic             w_mask_ok;
    logic             w_illegal;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_ext;

    assign w_req = i_op_valid & (i_mem_to_reg | (|i_mem_write));

    // Loads take their size from mem_read, stores from the write mask.
    always_comb begin
        w_size    = SZ_WORD;
        w_mask_ok = 1'b1;
        if (i_mem_to_reg) begin
            w_size = i_mem_read;
        end else begin
            case (i_mem_write)
                WM_BYTE: w_size = SZ_BYTE;
                WM_HALF: w_size = SZ_HALF;
                WM_WORD: w_size = SZ_WORD;
                default: w_mask_ok = 1'b0;
            endcase
        end

        w_illegal = (i_mem_to_reg & (|i_mem_write))
                  | (i_mem_to_reg & (i_mem_read == SZ_RSVD))
                  | ~w_mask_ok
                  | ((w_size == SZ_HALF) & i_addr[0])
                  | ((w_size == SZ_WORD) & (|i_addr[1:0]));

        case (w_size)
            SZ_BYTE: begin
                w_be    = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_store_data[7:0]}};
            end
            SZ_HALF: begin
                w_be    = 4'b0011 << {i_addr[1], 1'b0};
                w_wdata = {2{i_store_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = i_store_data;
            end
        endcase
    end

    load_extend u_load_extend (
        .i_rdata    (i_bus_rdata),
        .i_addr_lo  (i_addr[1:0]),
        .i_size     (w_size),
        .i_unsigned (i_load_unsigned),
        .o_data     (w_ext)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_align_err <= 1'b0;
            r_bus_err   <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_be    <= 4'b0000;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_load_data <= '0;
        end else begin
            r_done      <= 1'b0;
            r_align_err <= 1'b0;
            r_bus_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        if (w_illegal) begin
                            r_state     <= ST_DONE;
                            r_done      <= 1'b1;
                            r_align_err <= 1'b1;
                        end else begin
                            r_state     <= ST_REQ;
                            r_cnt       <= '0;
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= ~i_mem_to_reg;
                            r_bus_be    <= w_be;
                            r_bus_addr  <= i_addr[31:2];
                            r_bus_wdata <= w_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    // Ack is tested first so an ack in the last counted cycle beats the watchdog.
                    if (i_bus_ack) begin
                        r_state   <= ST_DONE;
                        r_bus_req <= 1'b0;
                        r_done    <= 1'b1;
                        if (i_mem_to_reg) begin
                            r_load_data <= w_ext;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_state     <= ST_DONE;
                        r_bus_req   <= 1'b0;
                        r_done      <= 1'b1;
                        r_bus_err   <= 1'b1;
                        r_load_data <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_stall     = w_req & (r_state != ST_DONE);
    assign o_done      = r_done;
    assign o_load_data = r_load_data;
    assign o_align_err = r_align_err;
    assign o_bus_err   = r_bus_err;
    assign o_bus_req   = r_bus_req;
    assign o_bus_we    = r_bus_we;
    assign o_bus_be    = r_bus_be;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a byte-arithmetic access model drives per-cycle expectations,
// one negedge process compares them, and literal values pin the model on the key vectors.
module tb_mem_access_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [3:0]  mem_write = 4'b0;
    logic [1:0]  mem_read = 2'b0;
    logic        mem_to_reg = 1'b0;
    logic        load_unsigned = 1'b0;
    logic [31:0] addr = 32'b0;
    logic [31:0] store_data = 32'b0;
    logic [31:0] bus_rdata = 32'b0;
    logic        bus_ack = 1'b0;

    logic        stall, done, align_err, bus_err, bus_req, bus_we;
    logic [31:0] load_data, bus_wdata;
    logic [3:0]  bus_be;
    logic [29:0] bus_addr;

    int n_tests = 0;
    int n_fail  = 0;

    logic        e_chk = 1'b0;
    logic        e_stall, e_req, e_done, e_aerr, e_berr, e_we, e_wd_chk, e_ld_chk;
    logic [3:0]  e_be;
    logic [29:0] e_baddr;
    logic [31:0] e_wd, e_ld;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_op_valid      (op_valid),
        .i_mem_write     (mem_write),
        .i_mem_read      (mem_read),
        .i_mem_to_reg    (mem_to_reg),
        .i_load_unsigned (load_unsigned),
        .i_addr          (addr),
        .i_store_data    (store_data),
        .o_stall         (stall),
        .o_done          (done),
        .o_load_data     (load_data),
        .o_align_err     (align_err),
        .o_bus_err       (bus_err),
        .o_bus_req       (bus_req),
        .o_bus_we        (bus_we),
        .o_bus_be        (bus_be),
        .o_bus_addr      (bus_addr),
        .o_bus_wdata     (bus_wdata),
        .i_bus_rdata     (bus_rdata),
        .i_bus_ack       (bus_ack)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (e_chk) begin
            chk("stall", 32'(stall), 32'(e_stall));
            chk("bus_req", 32'(bus_req), 32'(e_req));
            chk("done", 32'(done), 32'(e_done));
            chk("align_err", 32'(align_err), 32'(e_aerr));
            chk("bus_err", 32'(bus_err), 32'(e_berr));
            if (e_req) begin
                chk("bus_we", 32'(bus_we), 32'(e_we));
                chk("bus_be", 32'(bus_be), 32'(e_be));
                chk("bus_addr", 32'(bus_addr), 32'(e_baddr));
                if (e_wd_chk) chk("bus_wdata", bus_wdata, e_wd);
            end
            if (e_ld_chk) chk("load_data", load_data, e_ld);
        end
    end

    // Access model in bytes: size, alignment, lane mask, replication and extension by arithmetic.
    function automatic void model(input bit ld, input logic [3:0] wm, input logic [1:0] rs,
                                  input bit uns, input logic [31:0] a, input logic [31:0] sd,
                                  input logic [31:0] rd, output bit ill, output logic [3:0] be,
                                  output logic [31:0] wd, output logic [31:0] lv);
        int nb;
        int off;
        logic [31:0] msk;
        logic [31:0] raw;
        off = int'(a[1:0]);
        if (ld) nb = (rs == 2'd1) ? 1 : (rs == 2'd2) ? 2 : (rs == 2'd0) ? 4 : 0;
        else    nb = (wm == 4'b0001) ? 1 : (wm == 4'b0011) ? 2 : (wm == 4'b1111) ? 4 : 0;
        ill = (ld && wm != 4'b0) || nb == 0 || (off % ((nb == 0) ? 1 : nb)) != 0;
        be  = 4'(((1 << nb) - 1) << off);
        if (nb == 1)      wd = sd[7:0] * 32'h01010101;
        else if (nb == 2) wd = sd[15:0] * 32'h00010001;
        else              wd = sd;
        msk = (nb >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        raw = (rd >> (8 * off)) & msk;
        lv  = raw;
        if (!uns && nb > 0 && nb < 4 && raw[8 * nb - 1]) lv = raw | ~msk;
    endfunction

    // waits < 0 means the bus never acknowledges.
    task automatic run(input bit ld, input logic [3:0] wm, input logic [1:0] rs, input bit uns,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                       input int waits);
        bit          ill;
        logic [3:0]  be;
        logic [31:0] wd, lv;
        int          nreq, last;
        model(ld, wm, rs, uns, a, sd, rd, ill, be, wd, lv);
        nreq = ill ? 0 : ((waits < 0) ? TO : waits + 1);
        last = nreq + 1;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                op_valid = 1'b1; mem_to_reg = ld; mem_write = wm; mem_read = rs;
                load_unsigned = uns; addr = a; store_data = sd;
            end
            bus_ack   = (!ill && waits >= 0 && c == waits + 1);
            bus_rdata = bus_ack ? rd : 32'hDEAD_BEEF;
            e_chk    = 1'b1;
            e_stall  = (c < last);
            e_req    = (c >= 1 && c <= nreq);
            e_done   = (c == last);
            e_aerr   = ill && c == last;
            e_berr   = !ill && waits < 0 && c == last;
            e_we     = !ld;
            e_be     = be;
            e_baddr  = a[31:2];
            e_wd     = wd;
            e_wd_chk = !ld;
            e_ld_chk = (c == last) && !ill && (ld || waits < 0);
            e_ld     = (waits < 0) ? 32'h0 : lv;
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        op_valid = 1'b0; mem_write = 4'b0; mem_to_reg = 1'b0; bus_ack = 1'b0;
        e_chk = 1'b1; e_stall = 1'b0; e_req = 1'b0; e_done = 1'b0;
        e_aerr = 1'b0; e_berr = 1'b0; e_ld_chk = 1'b0; e_wd_chk = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_req", 32'(bus_req), 32'h0);
        chk("rst_we", 32'(bus_we), 32'h0);
        chk("rst_errs", {30'b0, align_err, bus_err}, 32'h0);
        chk("rst_be", 32'(bus_be), 32'h0);
        chk("rst_baddr", 32'(bus_addr), 32'h0);
        chk("rst_wdata", bus_wdata, 32'h0);
        chk("rst_ldata", load_data, 32'h0);
        rst_n = 1'b1;
        idle();

        run(1'b0, 4'b0001, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0);
        chk("sb_be", 32'(bus_be), 32'h8);
        chk("sb_wdata", bus_wdata, 32'hA5A5_A5A5);
        chk("sb_addr", 32'(bus_addr), 32'h400);
        idle();
        run(1'b1, 4'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0, 32'h80FF_7F01, 0);
        chk("lb_lane2", load_data, 32'hFFFF_FFFF);
        idle();
        run(1'b1, 4'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0, 32'h80FF_7F01, 0);
        chk("lbu_lane2", load_data, 32'h0000_00FF);
        idle();
        run(1'b1, 4'b0, 2'd1, 1'b0, 32'h0000_2003, 32'h0, 32'h80FF_7F01, 1);
        chk("lb_lane3", load_data, 32'hFFFF_FF80);
        idle();
        run(1'b1, 4'b0, 2'd2, 1'b0, 32'h0000_0012, 32'h0, 32'h8001_1234, 3);
        chk("lh_wait3", load_data, 32'hFFFF_8001);
        idle();
        run(1'b1, 4'b0, 2'd2, 1'b1, 32'h0000_0012, 32'h0, 32'h8001_1234, 0);
        chk("lhu_hi", load_data, 32'h0000_8001);
        idle();
        run(1'b1, 4'b0, 2'd0, 1'b0, 32'h0000_0040, 32'h0, 32'h1234_5678, 2);
        chk("lw", load_data, 32'h1234_5678);
        idle();
        run(1'b0, 4'b0011, 2'd0, 1'b0, 32'h0000_0206, 32'hCAFE_BEEF, 32'h0, 0);
        chk("sh_be", 32'(bus_be), 32'hC);
        chk("sh_wdata", bus_wdata, 32'hBEEF_BEEF);
        // Accepted in the very cycle after the previous DONE.
        run(1'b0, 4'b1111, 2'd0, 1'b0, 32'h0000_0300, 32'h1122_3344, 32'h0, 0);
        chk("sw_b2b_wdata", bus_wdata, 32'h1122_3344);
        idle();

        run(1'b0, 4'b1111, 2'd0, 1'b0, 32'h0000_0102, 32'h5, 32'h0, 0);
        idle();
        run(1'b1, 4'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0, 32'h0, 0);
        idle();
        run(1'b1, 4'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 0);
        idle();
        run(1'b1, 4'b0001, 2'd1, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 0);
        idle();
        run(1'b0, 4'b0111, 2'd0, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 0);
        idle();

        run(1'b1, 4'b0, 2'd0, 1'b0, 32'h0000_0080, 32'h0, 32'h0, -1);
        chk("timeout_ldata", load_data, 32'h0);
        run(1'b0, 4'b0001, 2'd0, 1'b0, 32'h0000_0005, 32'h0000_003C, 32'h0, 0);
        chk("after_to_wdata", bus_wdata, 32'h3C3C_3C3C);
        idle();
        // Ack on the final counted cycle must still complete normally.
        run(1'b1, 4'b0, 2'd0, 1'b0, 32'h0000_0084, 32'h0, 32'hA5A5_0F0F, TO - 1);
        chk("ack_last_cycle", load_data, 32'hA5A5_0F0F);
        idle();

        e_chk = 1'b0;
        @(posedge clk); #1;
        op_valid = 1'b1; mem_to_reg = 1'b1; mem_write = 4'b0; mem_read = 2'd0;
        addr = 32'h0000_0200; bus_ack = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_req", 32'(bus_req), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(bus_req), 32'h0);
        chk("arst_be", 32'(bus_be), 32'h0);
        op_valid = 1'b0;
        #1;
        chk("arst_stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        chk("arst_hold_req", 32'(bus_req), 32'h0);
        rst_n = 1'b1;
        idle();
        run(1'b1, 4'b0, 2'd0, 1'b0, 32'h0000_0200, 32'h0, 32'hFEED_F00D, 1);
        chk("post_rst_lw", load_data, 32'hFEED_F00D);
        idle();

        @(posedge clk); #1;
        e_chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit of the pipelined MIPS core. It consumes the decoded memory controls (byte-write mask, read size, load-unsigned flag) and the ALU address, then drives a variable-latency word-wide data-memory bus: byte-lane alignment, write-data replication, load extraction with sign/zero extension, and a timeout watchdog. While an access is in flight it stalls the pipeline.

## Interface
- `TIMEOUT_CYCLES`, 16: cycles `bus_req` may stay high without `bus_ack` before the access is aborted (≥2).
- `clk` input 1 core clock; all state changes on rising edge.
- `rst_n` input 1 asynchronous active-low reset.
- `op_valid` input 1 stage holds a valid instruction.
- `mem_write` input 4 write mask from decode: 0000 none, 0001 byte, 0011 half, 1111 word.
- `mem_read` input 2 load size: 0 word, 1 byte, 2 half, 3 reserved.
- `mem_to_reg` input 1 instruction is a load.
- `load_unsigned` input 1 zero-extend (LBU/LHU) instead of sign-extend.
- `addr` input 32 byte address from ALU.
- `store_data` input 32 register value to store.
- `stall` output 1 freeze upstream stages.
- `done` output 1 one-cycle pulse: access finished (or rejected).
- `load_data` output 32 extended load result, valid when `done` and load.
- `align_err` output 1 with `done`: misaligned or illegal request.
- `bus_err` output 1 with `done`: watchdog expired.
- `bus_req` output 1 access request, registered.
- `bus_we` output 1 write access.
- `bus_be` output 4 byte enables, bit i = byte lane i (little-endian).
- `bus_addr` output 30 word address = `addr[31:2]`.
- `bus_wdata` output 32 replicated store data.
- `bus_rdata` input 32 read word, sampled with `bus_ack`.
- `bus_ack` input 1 completion; may arrive in the first `bus_req` cycle.

## Operation
- Request = `op_valid & (mem_to_reg | mem_write != 0)`; otherwise unit idle, `stall`=0.
- Illegal: `mem_to_reg` with `mem_write != 0`; `mem_read`=3 on a load; half access with `addr[0]`=1; word access with `addr[1:0]`≠0; `mem_write` not in {0001,0011,1111}.
- Lanes: byte → `be = 0001 << addr[1:0]`; half → `0011 << {addr[1],1'b0}`; word → 1111. Loads use the same lanes; `bus_be` is driven on loads too.
- Store data: byte replicated ×4, half ×2, word as-is.
- Load: select lane(s) from `bus_rdata`, sign-extend unless `load_unsigned`; word unchanged.
- FSM: IDLE → (legal request) REQ; IDLE → (illegal) DONE with `align_err`; REQ → (`bus_ack`) DONE, latch extended data; REQ → (counter = TIMEOUT_CYCLES-1, no ack) DONE with `bus_err`, `load_data`=0; DONE → IDLE unconditionally.
- `stall = request & (state != DONE)`; inputs must be held stable while `stall`=1.
- Bus outputs (`bus_we`, `bus_be`, `bus_addr`, `bus_wdata`) registered on IDLE→REQ and held constant through REQ.

## Timing
- Reset: state IDLE, counter 0; `bus_req`, `bus_we`, `done`, `align_err`, `bus_err` = 0; `bus_be`=0000, `bus_addr`=0, `bus_wdata`=0, `load_data`=0. Reset mid-REQ drops `bus_req` immediately (asynchronous).
- Zero-wait ack: request seen cycle 0 (`stall`=1), `bus_req`=1 cycle 1 with ack, `done`=1/`stall`=0 cycle 2. Each extra wait cycle adds one.
- Illegal request: `stall`=1 cycle 0, `done`+`align_err` cycle 1, no `bus_req` ever.
- Timeout: `bus_req` high exactly TIMEOUT_CYCLES cycles, `done`+`bus_err` next cycle, `bus_req` low from that cycle. An ack in the final counted cycle wins over timeout.
- Back-to-back: next request is accepted in IDLE the cycle after DONE (one idle bubble minimum).
- Error flags and `done` are single-cycle; `load_data` holds until next completion.

## Structure
- Package `mem_access_pkg`: size encodings (WORD=0, BYTE=1, HALF=2), write-mask constants (0001/0011/1111), FSM state enum {IDLE, REQ, DONE}, counter width `$clog2(TIMEOUT_CYCLES)`.
- Sub-module `load_extend`: combinational lane select + sign/zero extension (`rdata`, `addr[1:0]`, size, unsigned → 32-bit result).

## Test plan
- SB: `addr`=0x1003, `store_data`=0x000000A5, ack at once → `bus_be`=1000, `bus_wdata`=0xA5A5A5A5, `bus_addr`=0x400, `done` cycle 2.
- LB vs LBU: `bus_rdata`=0x80FF7F01, `addr`=0x..2 → LB `load_data`=0x000000FF? no: lane 2 = 0xFF → LB 0xFFFFFFFF, LBU 0x000000FF; `addr`=..3 LB → 0xFFFFFF80.
- LH `addr[1]`=1, `bus_rdata`=0x8001_1234, 3 wait cycles → `load_data`=0xFFFF8001, `stall` high 5 cycles, `done` cycle 5.
- SW `addr`=0x102 → `align_err`+`done` cycle 1, `bus_req` never asserted; LH `addr`=0x101 same.
- No ack, TIMEOUT_CYCLES=16 → `bus_req` high 16 cycles, `bus_err`+`done` next, then IDLE and next request accepted.
- Assert `rst_n`=0 during REQ wait → `bus_req`,`stall`-driving state cleared immediately; after release, fresh LW completes normally.
